// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, default width, FSM states.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned OP_W         = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
    localparam logic [OP_W-1:0] OP_MULH = 4'd8;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd9;
    localparam logic [OP_W-1:0] OP_REM  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_DIV  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op <= OP_MULH) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between an execute requester and alu_issue_ctrl.
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) ();
    logic                req_valid;
    logic                req_ready;
    logic [OP_W-1:0]     req_op;
    logic [XLEN-1:0]     req_a;
    logic [XLEN-1:0]     req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_result;
    logic                rsp_is_equal;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_is_equal
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_is_equal
    );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring radix-2 divider (one quotient bit per cycle) with RISC-V corner results.
// ALU_ISSUE_DIV_FASTPATH_EN: divide-by-zero and overflow finish on the start edge.
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DIV_CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_rem,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [DIV_CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]      rem_q, quo_q, dvs_q, result_q;
    logic                 neg_quo_q, neg_rem_q, rem_op_q, b_zero_q, done_q;

    logic [XLEN-1:0]      a_mag, b_mag, rem_sh, rem_nx, quo_nx, fix_res;
    logic                 ge;

    // One restoring step plus the final sign fix-up of the step's outputs
    always_comb begin
        a_mag  = a[XLEN-1] ? -a : a;
        b_mag  = b[XLEN-1] ? -b : b;
        rem_sh = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        ge     = (rem_sh >= dvs_q);
        rem_nx = ge ? (rem_sh - dvs_q) : rem_sh;
        quo_nx = {quo_q[XLEN-2:0], ge};
        if (rem_op_q) begin
            fix_res = neg_rem_q ? -rem_nx : rem_nx;
        end else if (b_zero_q) begin
            fix_res = '1;
        end else begin
            fix_res = neg_quo_q ? -quo_nx : quo_nx;
        end
    end

`ifdef ALU_ISSUE_DIV_FASTPATH_EN
    logic            corner;
    logic [XLEN-1:0] corner_res;

    always_comb begin
        corner     = (b == '0) || ((a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
        corner_res = (b == '0) ? (is_rem ? a : '1) : (is_rem ? '0 : a);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                cnt_q     <= DIV_CNT_W'(XLEN);
                rem_q     <= '0;
                quo_q     <= a_mag;
                dvs_q     <= b_mag;
                neg_quo_q <= a[XLEN-1] ^ b[XLEN-1];
                neg_rem_q <= a[XLEN-1];
                rem_op_q  <= is_rem;
                b_zero_q  <= (b == '0);
`ifdef ALU_ISSUE_DIV_FASTPATH_EN
                if (corner) begin
                    cnt_q    <= '0;
                    result_q <= corner_res;
                    done_q   <= 1'b1;
                end
`endif
            end else if (cnt_q != '0) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator for the combinational RV64IM ALU; DIV/REM are diverted to seq_divider.
// Optional build macro: ALU_ISSUE_DIV_FASTPATH_EN (short latency for divide corner cases).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned DIV_CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_is_equal,
    output logic             busy
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            eq_q, eq_d;
    logic            ready_q, busy_q, rsp_valid_q;
    logic            div_start_c, div_done;
    logic [XLEN-1:0] div_result;

    seq_divider #(
        .XLEN      (XLEN),
        .DIV_CNT_W (DIV_CNT_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (div_start_c),
        .is_rem (bus.req_op == OP_REM),
        .a      (bus.req_a),
        .b      (bus.req_b),
        .done   (div_done),
        .result (div_result)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        eq_d        = eq_q;
        div_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    a_d  = bus.req_a;
                    b_d  = bus.req_b;
                    op_d = bus.req_op;
                    if (is_div_op(bus.req_op)) begin
                        state_d     = ST_DIV;
                        div_start_c = 1'b1;
                    end else if (is_alu_op(bus.req_op)) begin
                        state_d = ST_ALU;
                    end else begin
                        state_d = ST_RESP;
                        res_d   = '0;
                        eq_d    = 1'b0;
                    end
                end
            end
            ST_ALU: begin
                res_d   = alu_result;
                eq_d    = alu_is_equal;
                state_d = ST_RESP;
            end
            ST_DIV: begin
                if (div_done) begin
                    res_d   = div_result;
                    eq_d    = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            eq_q        <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            eq_q        <= eq_d;
            ready_q     <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign alu_a            = a_q;
    assign alu_b            = b_q;
    assign alu_op           = op_q;
    assign busy             = busy_q;
    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_is_equal = eq_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset corner sequences,
// and randomized transactions against a behavioural RV64IM reference.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam logic [63:0] MIN64    = 64'h8000_0000_0000_0000;
    localparam int          DIV_LAT  = 66;
`ifdef ALU_ISSUE_DIV_FASTPATH_EN
    localparam int          CORN_LAT = 2;
`else
    localparam int          CORN_LAT = 66;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_is_equal;
    logic        busy;
    int          checks;
    int          failures;

    alu_issue_ctrl_if #(.XLEN(64)) bus ();

    alu_issue_ctrl #(.XLEN(64), .DIV_CNT_W(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_is_equal (alu_is_equal),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV64IM semantics straight from the ISA definition
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0]  sa, sb;
        logic signed [127:0] pa, pb, p;
        sa = a;
        sb = b;
        pa = {{64{a[63]}}, a};
        pb = {{64{b[63]}}, b};
        p  = pa * pb;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[5:0];
            4'd6:  return a >> b[5:0];
            4'd7:  return a * b;
            4'd8:  return p[127:64];
            4'd9:  begin
                if (b == 64'd0) return '1;
                if (a == MIN64 && b == '1) return a;
                return sa / sb;
            end
            4'd10: begin
                if (b == 64'd0) return a;
                if (a == MIN64 && b == '1) return 64'd0;
                return sa % sb;
            end
            4'd11: return (sa < sb) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit tb_alu_op(input logic [3:0] op);
        return (op <= 4'd8) || (op == 4'd11);
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (tb_alu_op(op)) return 2;
        if (op == 4'd9 || op == 4'd10) begin
            if (b == 64'd0 || (a == MIN64 && b == '1)) return CORN_LAT;
            return DIV_LAT;
        end
        return 1;
    endfunction

    // Combinational ALU stand-in; DIV/REM and unknown ops return poison so misuse shows up
    always_comb begin
        if (tb_alu_op(alu_op)) alu_result = ref_res(alu_op, alu_a, alu_b);
        else                   alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        alu_is_equal = (alu_a == alu_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_res, input logic exp_eq,
                           input int lat, input int hold);
        int w;
        int edges;
        w = 0;
        while (!bus.req_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        check({tag, " req_ready before"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        edges = 1;
        while (!bus.rsp_valid && edges < 300) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " result"}, bus.rsp_result, exp_res);
        check({tag, " is_equal"}, 64'(bus.rsp_is_equal), 64'(exp_eq));
        check({tag, " alu_op held"}, 64'(alu_op), 64'(op));
        check({tag, " busy in resp"}, 64'(busy), 64'd1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 64'(bus.rsp_valid), 64'd1);
            check({tag, " hold result"}, bus.rsp_result, exp_res);
            check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, " valid dropped"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, " idle ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, " idle busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
        check({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, " rsp_result"}, bus.rsp_result, 64'd0);
        check({tag, " rsp_is_equal"}, 64'(bus.rsp_is_equal), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " alu_a"}, alu_a, 64'd0);
        check({tag, " alu_b"}, alu_b, 64'd0);
        check({tag, " alu_op"}, 64'(alu_op), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        eq;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [3:0]  rop;
        logic [63:0] ra, rb;
        int          sel;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        vecs[0]  = '{4'd0,  64'd5, 64'd5, 64'd10, 1'b1, 2, 0};
        vecs[1]  = '{4'd1,  64'd66, 64'd11, 64'd55, 1'b0, 2, 5};
        vecs[2]  = '{4'd9,  64'd66, 64'd11, 64'd6, 1'b0, DIV_LAT, 0};
        vecs[3]  = '{4'd10, 64'd62, 64'd3, 64'd2, 1'b0, DIV_LAT, 0};
        vecs[4]  = '{4'd9,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_LAT, 0};
        vecs[5]  = '{4'd10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, DIV_LAT, 0};
        vecs[6]  = '{4'd9,  64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, CORN_LAT, 0};
        vecs[7]  = '{4'd10, 64'd123, 64'd0, 64'd123, 1'b0, CORN_LAT, 0};
        vecs[8]  = '{4'd9,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, CORN_LAT, 0};
        vecs[9]  = '{4'd10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, CORN_LAT, 1};
        vecs[10] = '{4'd9,  MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 1'b0, CORN_LAT, 0};
        vecs[11] = '{4'd10, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, CORN_LAT, 0};
        vecs[12] = '{4'd9,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_LAT, 0};
        vecs[13] = '{4'd10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, DIV_LAT, 0};
        vecs[14] = '{4'd9,  64'd9, 64'd9, 64'd1, 1'b0, DIV_LAT, 0};
        vecs[15] = '{4'd13, 64'd3, 64'd3, 64'd0, 1'b0, 1, 0};
        vecs[16] = '{4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 2, 0};
        vecs[17] = '{4'd5,  64'd1, 64'd63, MIN64, 1'b0, 2, 0};
        vecs[18] = '{4'd8,  MIN64, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].eq, vecs[i].lat, vecs[i].hold);
        end

        // Reset partway through the divide iterations
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd9;
        bus.req_a     = 64'd1000;
        bus.req_b     = 64'd7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("middiv busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_vals("middiv reset");
        run_txn("after middiv", 4'd11, 64'd1, 64'd9, 64'd1, 1'b0, 2, 0);

        // Reset while a response is pending
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd0;
        bus.req_a     = 64'd40;
        bus.req_b     = 64'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("pending valid", 64'(bus.rsp_valid), 64'd1);
        check("pending result", bus.rsp_result, 64'd42);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_vals("resp reset");
        @(posedge clk); #1;
        check("no stale response", 64'(bus.rsp_valid), 64'd0);

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom(), $urandom()};
            sel = int'($urandom_range(0, 7));
            if (sel == 1 || sel == 5) ra = MIN64;
            case (sel)
                0:       rb = 64'd0;
                1:       rb = '1;
                2:       rb = ra;
                3:       rb = 64'($urandom_range(1, 100));
                default: rb = {$urandom(), $urandom()};
            endcase
            run_txn($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ref_res(rop, ra, rb),
                    tb_alu_op(rop) ? (ra == rb) : 1'b0, exp_lat(rop, ra, rb),
                    int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
